// File: rtl/mesi_emissor_receptor_pkg.sv
// Shared MESI encodings: line states, processor events and coherence bus messages.
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_M = 2'b00,
        ST_E = 2'b01,
        ST_S = 2'b10,
        ST_I = 2'b11
    } mesi_state_t;

    typedef enum logic [1:0] {
        RH = 2'b00,
        RM = 2'b01,
        WH = 2'b10,
        WM = 2'b11
    } proc_event_t;

    typedef enum logic [1:0] {
        BUS_NONE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_INV  = 2'b11
    } bus_msg_t;

endpackage

// File: rtl/mesi_emissor_receptor_if.sv
// Emitter/receiver signal bundle between the L1 state array, the coherence bus and the MESI logic.
interface mesi_emissor_receptor_if;

    logic       em_valid;
    logic [1:0] em_estado_in;
    logic [1:0] em_msg_in;
    logic       em_shared;
    logic [1:0] em_estado_out;
    logic [1:0] em_msg_out;
    logic       em_wb;
    logic       em_done;

    logic       rc_valid;
    logic [1:0] rc_estado_in;
    logic [1:0] rc_msg_in;
    logic [1:0] rc_estado_out;
    logic       rc_wb;
    logic       rc_abt_mem_acs;
    logic       rc_done;

    modport master (
        output em_valid, em_estado_in, em_msg_in, em_shared,
        input  em_estado_out, em_msg_out, em_wb, em_done,
        output rc_valid, rc_estado_in, rc_msg_in,
        input  rc_estado_out, rc_wb, rc_abt_mem_acs, rc_done
    );

    modport slave (
        input  em_valid, em_estado_in, em_msg_in, em_shared,
        output em_estado_out, em_msg_out, em_wb, em_done,
        input  rc_valid, rc_estado_in, rc_msg_in,
        output rc_estado_out, rc_wb, rc_abt_mem_acs, rc_done
    );

endinterface

// File: rtl/mesi_emissor_receptor_emissor.sv
// Processor-side MESI emitter: next state, bus message and victim write-back, registered.
module mesi_emissor
    import mesi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       em_valid_i,
    input  logic [1:0] em_estado_i,
    input  logic [1:0] em_msg_i,
    input  logic       em_shared_i,
    output logic [1:0] em_estado_o,
    output logic [1:0] em_msg_o,
    output logic       em_wb_o,
    output logic       em_done_o
);

    mesi_state_t estado_q, estado_d;
    bus_msg_t    msg_q, msg_d;
    logic        wb_q, wb_d;
    logic        done_q, done_d;

    mesi_state_t cur;
    proc_event_t ev;

    always_comb begin
        cur      = mesi_state_t'(em_estado_i);
        ev       = proc_event_t'(em_msg_i);
        estado_d = estado_q;
        msg_d    = BUS_NONE;
        wb_d     = 1'b0;
        done_d   = em_valid_i;

        if (em_valid_i) begin
            // An invalid line cannot hit: hits are promoted to the matching miss.
            if (cur == ST_I) begin
                if (ev == RH) ev = RM;
                if (ev == WH) ev = WM;
            end
            unique case (ev)
                RH: estado_d = cur;
                WH: begin
                    estado_d = ST_M;
                    msg_d    = (cur == ST_S) ? BUS_INV : BUS_NONE;
                end
                RM: begin
                    estado_d = em_shared_i ? ST_S : ST_E;
                    msg_d    = BUS_RD;
                    wb_d     = (cur == ST_M);
                end
                WM: begin
                    estado_d = ST_M;
                    msg_d    = BUS_RDX;
                    wb_d     = (cur == ST_M);
                end
                default: estado_d = estado_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_I;
            msg_q    <= BUS_NONE;
            wb_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            msg_q    <= msg_d;
            wb_q     <= wb_d;
            done_q   <= done_d;
        end
    end

    assign em_estado_o = estado_q;
    assign em_msg_o    = msg_q;
    assign em_wb_o     = wb_q;
    assign em_done_o   = done_q;

endmodule

// File: rtl/mesi_emissor_receptor_receptor.sv
// Snoop-side MESI receiver: next state, write-back and memory-abort, registered.
module mesi_receptor
    import mesi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rc_valid_i,
    input  logic [1:0] rc_estado_i,
    input  logic [1:0] rc_msg_i,
    output logic [1:0] rc_estado_o,
    output logic       rc_wb_o,
    output logic       rc_abt_o,
    output logic       rc_done_o
);

    mesi_state_t estado_q, estado_d;
    logic        wb_q, wb_d;
    logic        abt_q, abt_d;
    logic        done_q, done_d;

    mesi_state_t cur;
    bus_msg_t    msg;

    always_comb begin
        cur      = mesi_state_t'(rc_estado_i);
        msg      = bus_msg_t'(rc_msg_i);
        estado_d = estado_q;
        wb_d     = 1'b0;
        abt_d    = 1'b0;
        done_d   = rc_valid_i;

        if (rc_valid_i) begin
            if (msg == BUS_NONE) begin
                estado_d = cur;
            end else begin
                estado_d = (msg == BUS_RD && cur != ST_I) ? ST_S : ST_I;
                // A modified line supplies data on reads; an Invalidate against M is illegal, so flush without aborting memory.
                if (cur == ST_M) begin
                    wb_d  = 1'b1;
                    abt_d = (msg != BUS_INV);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_I;
            wb_q     <= 1'b0;
            abt_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            wb_q     <= wb_d;
            abt_q    <= abt_d;
            done_q   <= done_d;
        end
    end

    assign rc_estado_o = estado_q;
    assign rc_wb_o     = wb_q;
    assign rc_abt_o    = abt_q;
    assign rc_done_o   = done_q;

endmodule

// File: rtl/mesi_emissor_receptor.sv
// MESI coherence logic for one L1 line slot: independent emitter and receiver halves.
module mesi_emissor_receptor
    import mesi_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    mesi_emissor_receptor_if.slave       bus
);

    mesi_emissor u_emissor (
        .clock       (clock),
        .reset       (reset),
        .em_valid_i  (bus.em_valid),
        .em_estado_i (bus.em_estado_in),
        .em_msg_i    (bus.em_msg_in),
        .em_shared_i (bus.em_shared),
        .em_estado_o (bus.em_estado_out),
        .em_msg_o    (bus.em_msg_out),
        .em_wb_o     (bus.em_wb),
        .em_done_o   (bus.em_done)
    );

    mesi_receptor u_receptor (
        .clock       (clock),
        .reset       (reset),
        .rc_valid_i  (bus.rc_valid),
        .rc_estado_i (bus.rc_estado_in),
        .rc_msg_i    (bus.rc_msg_in),
        .rc_estado_o (bus.rc_estado_out),
        .rc_wb_o     (bus.rc_wb),
        .rc_abt_o    (bus.rc_abt_mem_acs),
        .rc_done_o   (bus.rc_done)
    );

endmodule

// File: tb/tb_mesi_emissor_receptor.sv
// Directed bench for mesi_emissor_receptor with hand-computed expected outputs.
module tb_mesi_emissor_receptor;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mesi_emissor_receptor_if bus ();

    mesi_emissor_receptor dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // em vector: {estado[1:0], msg[1:0], wb, done}
    function automatic logic [5:0] em_obs();
        return {bus.em_estado_out, bus.em_msg_out, bus.em_wb, bus.em_done};
    endfunction

    // rc vector: {estado[1:0], wb, abt, done}
    function automatic logic [4:0] rc_obs();
        return {bus.rc_estado_out, bus.rc_wb, bus.rc_abt_mem_acs, bus.rc_done};
    endfunction

    task automatic chk_em(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = em_obs();
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: em {st,msg,wb,done} got %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_rc(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = rc_obs();
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: rc {st,wb,abt,done} got %b required %b", tag, obs, exp);
        end
    endtask

    task automatic drive_em(input logic v, input logic [1:0] st, input logic [1:0] ev, input logic sh);
        bus.em_valid     = v;
        bus.em_estado_in = st;
        bus.em_msg_in    = ev;
        bus.em_shared    = sh;
    endtask

    task automatic drive_rc(input logic v, input logic [1:0] st, input logic [1:0] msg);
        bus.rc_valid     = v;
        bus.rc_estado_in = st;
        bus.rc_msg_in    = msg;
    endtask

    // Drive after a rising edge, let the next edge sample, check 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with both valids asserted: requests dropped.
        drive_em(1'b1, 2'b11, 2'b11, 1'b0);
        drive_rc(1'b1, 2'b00, 2'b01);
        reset = 1'b1;
        step();
        step();
        chk_em("reset_em", 6'b11_00_0_0);
        chk_rc("reset_rc", 5'b11_0_0_0);
        reset = 1'b0;
        drive_em(1'b0, 2'b00, 2'b00, 1'b0);
        drive_rc(1'b0, 2'b00, 2'b00);
        step();
        chk_em("idle_after_reset_em", 6'b11_00_0_0);

        drive_em(1'b1, 2'b11, 2'b01, 1'b0);      // I + RM, unshared
        step();
        chk_em("I_RM_unshared", 6'b01_01_0_1);
        chk_rc("rc_idle_during_em", 5'b11_0_0_0);

        drive_em(1'b1, 2'b11, 2'b01, 1'b1);      // I + RM, shared
        step();
        chk_em("I_RM_shared", 6'b10_01_0_1);

        drive_em(1'b1, 2'b10, 2'b10, 1'b0);      // S + WH
        step();
        chk_em("S_WH", 6'b00_11_0_1);

        drive_em(1'b1, 2'b01, 2'b10, 1'b0);      // E + WH silent upgrade
        step();
        chk_em("E_WH", 6'b00_00_0_1);

        drive_em(1'b1, 2'b00, 2'b11, 1'b0);      // M + WM
        step();
        chk_em("M_WM", 6'b00_10_1_1);

        drive_em(1'b1, 2'b00, 2'b01, 1'b1);      // M + RM shared
        step();
        chk_em("M_RM_shared", 6'b10_01_1_1);

        drive_em(1'b1, 2'b11, 2'b00, 1'b0);      // I + RH promoted to RM
        step();
        chk_em("I_RH_as_RM", 6'b01_01_0_1);

        drive_em(1'b1, 2'b11, 2'b10, 1'b1);      // I + WH promoted to WM
        step();
        chk_em("I_WH_as_WM", 6'b00_10_0_1);

        drive_em(1'b0, 2'b00, 2'b00, 1'b0);
        drive_rc(1'b1, 2'b00, 2'b01);            // M + BusRd
        step();
        chk_rc("rc_M_BusRd", 5'b10_1_1_1);
        chk_em("em_idle_holds", 6'b00_00_0_0);

        drive_rc(1'b1, 2'b10, 2'b10);            // S + BusRdX
        step();
        chk_rc("rc_S_BusRdX", 5'b11_0_0_1);

        drive_rc(1'b1, 2'b01, 2'b01);            // E + BusRd
        step();
        chk_rc("rc_E_BusRd", 5'b10_0_0_1);

        drive_rc(1'b1, 2'b00, 2'b00);            // M + none
        step();
        chk_rc("rc_M_none", 5'b00_0_0_1);

        drive_rc(1'b1, 2'b11, 2'b01);            // I + BusRd
        step();
        chk_rc("rc_I_BusRd", 5'b11_0_0_1);

        drive_em(1'b1, 2'b10, 2'b00, 1'b0);      // simultaneous: S + RH
        drive_rc(1'b1, 2'b00, 2'b11);            // M + Invalidate
        step();
        chk_em("sim_em_S_RH", 6'b10_00_0_1);
        chk_rc("sim_rc_M_Inv", 5'b11_1_0_1);

        drive_em(1'b0, 2'b00, 2'b11, 1'b1);
        drive_rc(1'b0, 2'b00, 2'b01);
        step();
        chk_em("drop_em_hold", 6'b10_00_0_0);
        chk_rc("drop_rc_hold", 5'b11_0_0_0);

        drive_em(1'b1, 2'b00, 2'b11, 1'b0);      // reset beats an in-flight request
        drive_rc(1'b1, 2'b00, 2'b01);
        reset = 1'b1;
        step();
        chk_em("reset_priority_em", 6'b11_00_0_0);
        chk_rc("reset_priority_rc", 5'b11_0_0_0);
        reset = 1'b0;
        drive_em(1'b0, 2'b00, 2'b00, 1'b0);
        drive_rc(1'b0, 2'b00, 2'b00);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
